// File: rtl/ac97_pkg.sv
//==============================================================================
// Module      : ac97_pkg
// Description : Shared AC97 register addresses, scheduler states and the
//               volume/source data-word mappings.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ac97_pkg;

    localparam logic [7:0] AC97_MASTER_VOL = 8'h02;
    localparam logic [7:0] AC97_HP_VOL     = 8'h04;
    localparam logic [7:0] AC97_MIC_VOL    = 8'h0E;
    localparam logic [7:0] AC97_PCM_VOL    = 8'h18;
    localparam logic [7:0] AC97_REC_SEL    = 8'h1A;
    localparam logic [7:0] AC97_REC_GAIN   = 8'h1C;

    localparam int INIT_LEN = 6;

    typedef enum logic [2:0] {
        WAIT_READY = 3'd0,
        INIT       = 3'd1,
        ISSUE      = 3'd2,
        NEXT       = 3'd3,
        IDLE       = 3'd4
    } state_t;

    // Codec attenuation runs opposite to the user volume; volume 0 also sets mute.
    function automatic logic [15:0] vol_map(input logic [4:0] vol);
        logic [4:0] atten;
        atten = 5'd31 - vol;
        return {(vol == 5'd0), 2'b00, atten, 3'b000, atten};
    endfunction

    function automatic logic [15:0] src_map(input logic [2:0] src);
        return {5'b00000, src, 5'b00000, src};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ac97_cmd_scheduler_if.sv
//==============================================================================
// Module      : ac97_cmd_scheduler_if
// Description : Command handshake between the scheduler (master) and the
//               AC97 datapath command slots (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ac97_cmd_scheduler_if;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_latched;

    modport master (
        output cmd_addr,
        output cmd_data,
        output cmd_valid,
        input  cmd_latched
    );

    modport slave (
        input  cmd_addr,
        input  cmd_data,
        input  cmd_valid,
        output cmd_latched
    );
endinterface

`default_nettype wire

// File: rtl/ac97_init_rom.sv
//==============================================================================
// Module      : ac97_init_rom
// Description : Combinational power-up init table; volume and source entries
//               take their data words from the live maps.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ac97_init_rom
    import ac97_pkg::*;
(
    input  logic [2:0]  idx,
    input  logic [15:0] vol_data,
    input  logic [15:0] src_data,
    output logic [7:0]  addr,
    output logic [15:0] data
);

    always_comb begin
        addr = 8'h00;
        data = 16'h0000;
        case (idx)
            3'd0: begin addr = AC97_MASTER_VOL; data = vol_data;  end
            3'd1: begin addr = AC97_HP_VOL;     data = vol_data;  end
            3'd2: begin addr = AC97_PCM_VOL;    data = 16'h0808;  end
            3'd3: begin addr = AC97_REC_SEL;    data = src_data;  end
            3'd4: begin addr = AC97_REC_GAIN;   data = 16'h0F0F;  end
            3'd5: begin addr = AC97_MIC_VOL;    data = 16'h0008;  end
            default: begin addr = 8'h00;        data = 16'h0000;  end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ac97_cmd_scheduler.sv
//==============================================================================
// Module      : ac97_cmd_scheduler
// Description : Waits for codec ready, plays the init table, then arbitrates
//               volume/source writes onto the single command path.
//               AC97_VOL_RAMP_EN: run-mode volume moves one atten step per pair.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ac97_cmd_scheduler
    import ac97_pkg::*;
#(
    parameter int READY_HOLD = 256,
    parameter int TIMEOUT    = 8192,
    parameter int MAX_RETRY  = 2
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  ac97_ready_sig,
    input  logic [4:0]            volume,
    input  logic [2:0]            source,
    ac97_cmd_scheduler_if.master  cmd,
    output logic                  init_done,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int c_CNT_W = $clog2(READY_HOLD + 1);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);
    localparam int c_RTY_W = $clog2(MAX_RETRY + 2);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(READY_HOLD - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX   = c_RTY_W'(MAX_RETRY);
    localparam logic [2:0]         c_IDX_LAST  = 3'(INIT_LEN - 1);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_ready_cnt;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_RTY_W-1:0]   r_retries;
    logic [2:0]           r_idx;
    logic [7:0]           r_cmd_addr;
    logic [15:0]          r_cmd_data;
    logic                 r_cmd_valid;
    logic                 r_init_done;
    logic                 r_err_timeout;
    logic                 r_vol_second;
    logic [4:0]           r_vol_s1, r_vol_sync, r_shadow_vol, r_cap_vol;
    logic [2:0]           r_src_s1, r_src_sync, r_shadow_src, r_cap_src;
    logic [4:0]           w_vol_step;
    logic [7:0]           w_rom_addr;
    logic [15:0]          w_rom_data;
    logic                 w_pv, w_ps;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_vol_s1   <= 5'd0;
            r_vol_sync <= 5'd0;
            r_src_s1   <= 3'd0;
            r_src_sync <= 3'd0;
        end else begin
            r_vol_s1   <= volume;
            r_vol_sync <= r_vol_s1;
            r_src_s1   <= source;
            r_src_sync <= r_src_s1;
        end
    end

`ifdef AC97_VOL_RAMP_EN
    assign w_vol_step = (r_vol_sync > r_shadow_vol) ? (r_shadow_vol + 5'd1)
                                                    : (r_shadow_vol - 5'd1);
`else
    assign w_vol_step = r_vol_sync;
`endif

    assign w_pv = (r_vol_sync != r_shadow_vol);
    assign w_ps = (r_src_sync != r_shadow_src);

    ac97_init_rom u_init_rom (
        .idx      (r_idx),
        .vol_data (vol_map(r_vol_sync)),
        .src_data (src_map(r_src_sync)),
        .addr     (w_rom_addr),
        .data     (w_rom_data)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= WAIT_READY;
            r_ready_cnt   <= '0;
            r_timer       <= '0;
            r_retries     <= '0;
            r_idx         <= 3'd0;
            r_cmd_addr    <= 8'h00;
            r_cmd_data    <= 16'h0000;
            r_cmd_valid   <= 1'b0;
            r_init_done   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_vol_second  <= 1'b0;
            r_shadow_vol  <= 5'd0;
            r_shadow_src  <= 3'd0;
            r_cap_vol     <= 5'd0;
            r_cap_src     <= 3'd0;
        end else if (r_state != WAIT_READY && !ac97_ready_sig) begin
            // Codec went back into reset: abandon everything and re-init.
            r_state      <= WAIT_READY;
            r_ready_cnt  <= '0;
            r_timer      <= '0;
            r_retries    <= '0;
            r_cmd_valid  <= 1'b0;
            r_init_done  <= 1'b0;
            r_vol_second <= 1'b0;
        end else begin
            case (r_state)
                WAIT_READY: begin
                    if (!ac97_ready_sig) begin
                        r_ready_cnt <= '0;
                    end else if (r_ready_cnt == c_HOLD_LAST) begin
                        r_ready_cnt <= '0;
                        r_idx       <= 3'd0;
                        r_state     <= INIT;
                    end else begin
                        r_ready_cnt <= r_ready_cnt + 1'b1;
                    end
                end

                INIT: begin
                    r_cmd_addr  <= w_rom_addr;
                    r_cmd_data  <= w_rom_data;
                    r_cap_vol   <= r_vol_sync;
                    r_cap_src   <= r_src_sync;
                    r_cmd_valid <= 1'b1;
                    r_timer     <= '0;
                    r_retries   <= '0;
                    r_state     <= ISSUE;
                end

                ISSUE: begin
                    if (cmd.cmd_latched) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= NEXT;
                        if (r_cmd_addr == AC97_MASTER_VOL || r_cmd_addr == AC97_HP_VOL)
                            r_shadow_vol <= r_cap_vol;
                        if (r_cmd_addr == AC97_REC_SEL)
                            r_shadow_src <= r_cap_src;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_timer <= '0;
                        if (r_retries < c_RTY_MAX) begin
                            r_retries <= r_retries + 1'b1;
                        end else begin
                            r_err_timeout <= 1'b1;
                            r_cmd_valid   <= 1'b0;
                            r_state       <= NEXT;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                NEXT: begin
                    if (!r_init_done) begin
                        if (r_idx == c_IDX_LAST) begin
                            r_init_done <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= INIT;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end

                IDLE: begin
                    // A volume pair is never split by a source write.
                    if (r_vol_second) begin
                        r_cmd_addr   <= AC97_HP_VOL;
                        r_cmd_data   <= vol_map(r_cap_vol);
                        r_vol_second <= 1'b0;
                        r_cmd_valid  <= 1'b1;
                        r_timer      <= '0;
                        r_retries    <= '0;
                        r_state      <= ISSUE;
                    end else if (w_pv) begin
                        r_cap_vol    <= w_vol_step;
                        r_cmd_addr   <= AC97_MASTER_VOL;
                        r_cmd_data   <= vol_map(w_vol_step);
                        r_vol_second <= 1'b1;
                        r_cmd_valid  <= 1'b1;
                        r_timer      <= '0;
                        r_retries    <= '0;
                        r_state      <= ISSUE;
                    end else if (w_ps) begin
                        r_cap_src    <= r_src_sync;
                        r_cmd_addr   <= AC97_REC_SEL;
                        r_cmd_data   <= src_map(r_src_sync);
                        r_cmd_valid  <= 1'b1;
                        r_timer      <= '0;
                        r_retries    <= '0;
                        r_state      <= ISSUE;
                    end
                end

                default: r_state <= WAIT_READY;
            endcase
        end
    end

    assign cmd.cmd_addr  = r_cmd_addr;
    assign cmd.cmd_data  = r_cmd_data;
    assign cmd.cmd_valid = r_cmd_valid;
    assign init_done     = r_init_done;
    assign err_timeout   = r_err_timeout;
    assign busy          = (r_state != IDLE);

endmodule

`default_nettype wire
